// File: rtl/wr_packer_pkg.sv
// Package: wr_packer_pkg
// Shared types and constants for the write-side stream packer.
//   state_t  : packer FSM encoding (idle / filling a word / word waiting in hold)
//   RATIO    : beats per FIFO word for the default 8-bit word / 2-bit beat build
//   LANE_W   : lane counter width for the default build
//   WCNT_W   : width of the pushed-word counter
//   lane_bits: lane counter width for an arbitrary ratio (at least one bit)
package wr_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_IN_W  = 2;
    localparam int RATIO     = DEF_WIDTH / DEF_IN_W;
    localparam int LANE_W    = $clog2(RATIO);
    localparam int WCNT_W    = 16;

    function automatic int lane_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/wr_packer_hold.sv
// Module: wr_packer_hold
// One-entry output buffer in front of the FIFO write port.
//   wr_clk, rst_n : clock, asynchronous active-low reset
//   load          : a completed word enters the buffer on this edge
//   load_data     : the completed word
//   fifo_full     : FIFO full flag
//   fifo_din      : held word driven to the FIFO (kept after push)
//   hold_valid    : buffer holds a word not yet written
//   fifo_wr_en    : FIFO write strobe, combinational through fifo_full
// A load in the same cycle as a push replaces the word without a bubble.
module wr_packer_hold #(
    parameter int WIDTH = 8
) (
    input  logic             wr_clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             fifo_full,
    output logic [WIDTH-1:0] fifo_din,
    output logic             hold_valid,
    output logic             fifo_wr_en
);

    assign fifo_wr_en = hold_valid && !fifo_full;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            fifo_din   <= '0;
        end else if (load) begin
            hold_valid <= 1'b1;
            fifo_din   <= load_data;
        end else if (fifo_wr_en) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/wr_stream_packer.sv
// Module: wr_stream_packer
// Packs RATIO = WIDTH/IN_W narrow valid/ready beats into one FIFO word and
// writes it through a one-entry hold buffer that respects fifo_full.
// Beat k of a word lands in bits [k*IN_W +: IN_W]; s_last (or, optionally,
// an idle timeout) closes a partial word, zero-padding the unused lanes.
// Optional feature macro: WR_PACKER_TIMEOUT_EN (idle-timeout partial flush
// after TIMEOUT_CYC idle cycles while filling). Ports are identical either way.
// Ports:
//   wr_clk, rst_n          : write clock, asynchronous active-low reset
//   s_valid/s_ready        : input beat handshake
//   s_data, s_last         : input beat and end-of-burst marker
//   fifo_din, fifo_wr_en   : FIFO write port
//   fifo_full              : FIFO full flag
//   word_cnt               : words pushed into the FIFO, wraps at 2^16
//   partial_flush          : one-cycle pulse when a zero-padded word enters hold
module wr_stream_packer
    import wr_packer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int IN_W        = DEF_IN_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_last,
    output logic [WIDTH-1:0]  fifo_din,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic [WCNT_W-1:0] word_cnt,
    output logic              partial_flush
);

    localparam int LANES  = WIDTH / IN_W;
    localparam int LCNT_W = lane_bits(LANES);
    localparam logic [LCNT_W-1:0] LAST_LANE = LCNT_W'(LANES - 1);

    if ((WIDTH % IN_W) != 0 || LANES < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("wr_stream_packer: illegal WIDTH/IN_W/TIMEOUT_CYC combination");
    end

    state_t            state, state_next;
    logic [LCNT_W-1:0] lane_cnt, lane_next;
    logic [WIDTH-1:0]  acc, word_next, load_data;
    logic              hold_valid, accept, complete, load, timeout_flush;

    // The ready path deliberately ignores s_valid.
    assign s_ready  = !hold_valid || !fifo_full;
    assign accept   = s_valid && s_ready;
    assign complete = accept && (s_last || lane_cnt == LAST_LANE);
    assign load     = complete || timeout_flush;

    // The accumulator keeps unfilled lanes at zero, so inserting the current
    // beat yields a correctly zero-padded word for any completion point.
    always_comb begin
        word_next = acc;
        word_next[int'(lane_cnt) * IN_W +: IN_W] = s_data;
    end

    // A timeout flush never coincides with an accepted beat.
    assign load_data = timeout_flush ? acc : word_next;

    always_comb begin
        lane_next = lane_cnt;
        if (load) begin
            lane_next = '0;
        end else if (accept) begin
            lane_next = lane_cnt + 1'b1;
        end
    end

`ifdef WR_PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_tick;

    assign idle_tick     = (state == ST_FILL) && !accept;
    // Saturates at IDLE_LAST so a flush deferred by a valid hold fires as
    // soon as the hold drains.
    assign timeout_flush = idle_tick && (idle_cnt == IDLE_LAST) && !hold_valid;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!idle_tick || timeout_flush) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_LAST) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_flush = 1'b0;
`endif

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt      <= '0;
            acc           <= '0;
            partial_flush <= 1'b0;
            word_cnt      <= '0;
            state         <= ST_IDLE;
        end else begin
            lane_cnt      <= lane_next;
            acc           <= load ? '0 : (accept ? word_next : acc);
            partial_flush <= (complete && lane_cnt != LAST_LANE) || timeout_flush;
            if (fifo_wr_en) begin
                word_cnt <= word_cnt + WCNT_W'(1);
            end
            state         <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (load) begin
                    state_next = ST_HOLD;
                end else if (accept) begin
                    state_next = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (load) begin
                    state_next = ST_HOLD;
                end else if (fifo_wr_en) begin
                    state_next = (lane_next != '0) ? ST_FILL : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    wr_packer_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .wr_clk    (wr_clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .fifo_full (fifo_full),
        .fifo_din  (fifo_din),
        .hold_valid(hold_valid),
        .fifo_wr_en(fifo_wr_en)
    );

endmodule

// File: tb/tb_wr_stream_packer.sv
// Testbench for wr_stream_packer (WIDTH=8, IN_W=2, TIMEOUT_CYC=8).
// Directed vector table, hand-written corner sequences and a randomized run
// checked against a cycle-level arithmetic reference model and a word
// scoreboard. Define WR_PACKER_TIMEOUT_EN for both DUT and bench to cover
// the idle-timeout build.
module tb_wr_stream_packer;
    import wr_packer_pkg::*;

    localparam int WIDTH = 8;
    localparam int IN_W  = 2;
    localparam int TO    = 8;

    logic        wr_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [1:0]  s_data = 2'd0;
    logic        s_last = 1'b0;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full = 1'b0;
    logic [15:0] word_cnt;
    logic        partial_flush;

    always #5 wr_clk = ~wr_clk;

    wr_stream_packer #(
        .WIDTH(WIDTH),
        .IN_W(IN_W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .fifo_din     (fifo_din),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_full    (fifo_full),
        .word_cnt     (word_cnt),
        .partial_flush(partial_flush)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words are built arithmetically from beats.
    bit   m_hv;
    int   m_din;
    int   m_beats;
    int   m_word;
    bit   m_pf;
    int   m_wcnt;
    int   m_idle;
    int   cyc;
    int   exp_words[$];
    int   got_words[$];
    int   push_cyc[$];

    task automatic model_reset();
        m_hv = 0; m_din = 0; m_beats = 0; m_word = 0; m_pf = 0; m_wcnt = 0; m_idle = 0;
        exp_words.delete(); got_words.delete(); push_cyc.delete();
    endtask

    // Called at posedge+1; drives one cycle, checks, advances to next posedge+1.
    task automatic cycle(input bit v, input logic [1:0] d, input bit l, input bit f);
        bit rdy, push, acc, load;
        int word_l;
        s_valid = v; s_data = d; s_last = l; fifo_full = f;
        #1;
        rdy  = !m_hv || !f;
        push = m_hv && !f;
        acc  = v && rdy;
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(push));
        chk("fifo_din", 32'(fifo_din), 32'(m_din));
        chk("word_cnt", 32'(word_cnt), 32'(m_wcnt % 65536));
        chk("partial_flush", 32'(partial_flush), 32'(m_pf));
        if (fifo_wr_en) begin
            got_words.push_back(int'(fifo_din));
            push_cyc.push_back(cyc);
        end
        @(posedge wr_clk);
        #1;
        cyc++;
        m_pf = 0; load = 0; word_l = 0;
        if (acc) begin
            m_word += int'(d) * (1 << (IN_W * m_beats));
            m_beats++;
            m_idle = 0;
            if (m_beats == RATIO || l) begin
                load = 1; word_l = m_word; m_pf = (m_beats < RATIO);
                m_beats = 0; m_word = 0;
            end
        end
`ifdef WR_PACKER_TIMEOUT_EN
        else if (m_beats > 0) begin
            if (m_idle == TO - 1 && !m_hv) begin
                load = 1; word_l = m_word; m_pf = 1;
                m_beats = 0; m_word = 0; m_idle = 0;
            end else if (m_idle < TO - 1) begin
                m_idle++;
            end
        end
`endif
        if (push) m_wcnt++;
        if (load) begin
            m_hv = 1; m_din = word_l; exp_words.push_back(word_l);
        end else if (push) begin
            m_hv = 0;
        end
    endtask

    task automatic sb_check(input string name);
        int n;
        chk({name, "_count"}, 32'(got_words.size()), 32'(exp_words.size()));
        n = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
        for (int i = 0; i < n; i++) chk({name, "_word"}, 32'(got_words[i]), 32'(exp_words[i]));
        got_words.delete(); exp_words.delete(); push_cyc.delete();
    endtask

    task automatic do_reset();
        s_valid = 0; s_data = 0; s_last = 0; fifo_full = 0;
        rst_n = 0;
        repeat (2) @(posedge wr_clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    typedef struct {
        bit         v;
        logic [1:0] d;
        bit         l;
        bit         f;
        bit         rdy;
        bit         wr;
        logic [7:0] din;
        bit         pf;
        int         wcnt;
    } vec_t;

    vec_t tbl[17];
    int   d4[16];
    int   w;
    int   base;

    initial begin
        tbl[0]  = '{1, 2'd1, 0, 0, 1, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 2'd2, 0, 0, 1, 0, 8'h00, 0, 0};
        tbl[2]  = '{1, 2'd3, 0, 0, 1, 0, 8'h00, 0, 0};
        tbl[3]  = '{1, 2'd0, 0, 0, 1, 1, 8'h39, 0, 0};
        tbl[4]  = '{0, 2'd0, 0, 0, 1, 0, 8'h39, 0, 1};
        tbl[5]  = '{1, 2'd3, 0, 0, 1, 0, 8'h39, 0, 1};
        tbl[6]  = '{1, 2'd1, 1, 0, 1, 1, 8'h07, 1, 1};
        tbl[7]  = '{0, 2'd0, 0, 0, 1, 0, 8'h07, 0, 2};
        tbl[8]  = '{1, 2'd0, 0, 0, 1, 0, 8'h07, 0, 2};
        tbl[9]  = '{1, 2'd0, 0, 0, 1, 0, 8'h07, 0, 2};
        tbl[10] = '{1, 2'd0, 0, 0, 1, 0, 8'h07, 0, 2};
        tbl[11] = '{1, 2'd2, 1, 0, 1, 1, 8'h80, 0, 2};
        tbl[12] = '{0, 2'd0, 0, 0, 1, 0, 8'h80, 0, 3};
        tbl[13] = '{1, 2'd2, 1, 0, 1, 1, 8'h02, 1, 3};
        tbl[14] = '{1, 2'd1, 1, 1, 0, 0, 8'h02, 0, 3};
        tbl[15] = '{1, 2'd1, 1, 0, 1, 1, 8'h01, 1, 4};
        tbl[16] = '{0, 2'd0, 0, 0, 1, 0, 8'h01, 0, 5};
        cyc = 0;

        do_reset();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_din", 32'(fifo_din), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_partial_flush", 32'(partial_flush), 32'd0);

        // Directed vectors: full words, partial words, s_last on the last
        // lane, and a full stall followed by a same-edge push and reload.
        for (int i = 0; i < 17; i++) begin
            s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l; fifo_full = tbl[i].f;
            #1;
            chk($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
            @(posedge wr_clk);
            #1;
            chk($sformatf("tbl%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].wr));
            chk($sformatf("tbl%0d_din", i), 32'(fifo_din), 32'(tbl[i].din));
            chk($sformatf("tbl%0d_pf", i), 32'(partial_flush), 32'(tbl[i].pf));
            chk($sformatf("tbl%0d_word_cnt", i), 32'(word_cnt), 32'(tbl[i].wcnt));
        end

        // Continuous stream with the FIFO full for 10 cycles while hold is valid.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 2'($urandom_range(0, 3)), 0, 0);
        chk("full_hold_valid", 32'(fifo_wr_en), 32'd1);
        w = m_din;
        for (int i = 0; i < 10; i++) cycle(1, 2'($urandom_range(0, 3)), 0, 1);
        chk("full_din_stable", 32'(fifo_din), 32'(w));
        for (int i = 0; i < 12; i++) cycle(1, 2'($urandom_range(0, 3)), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        chk("full_word_cnt", 32'(word_cnt), 32'(exp_words.size()));
        sb_check("full_sb");

        // Four back-to-back words at full rate.
        for (int i = 0; i < 16; i++) begin
            d4[i] = $urandom_range(0, 3);
            cycle(1, 2'(d4[i]), 0, 0);
        end
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
        chk("b2b_count", 32'(got_words.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_words.size(); i++) begin
            w = d4[4*i] + d4[4*i+1] * 4 + d4[4*i+2] * 16 + d4[4*i+3] * 64;
            chk($sformatf("b2b_word%0d", i), 32'(got_words[i]), 32'(w));
        end
        for (int i = 0; i + 1 < push_cyc.size(); i++)
            chk("b2b_spacing", 32'(push_cyc[i+1] - push_cyc[i]), 32'd4);
        sb_check("b2b_sb");

        // Asynchronous reset in the middle of a word.
        cycle(1, 2'd1, 0, 0);
        cycle(1, 2'd3, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("mid_rst_din", 32'(fifo_din), 32'd0);
        chk("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("mid_rst_pf", 32'(partial_flush), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
        @(posedge wr_clk);
        #1;
        rst_n = 1;
        model_reset();
        cycle(1, 2'd2, 0, 0);
        cycle(1, 2'd2, 0, 0);
        cycle(1, 2'd1, 0, 0);
        cycle(1, 2'd3, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("post_rst_count", 32'(got_words.size()), 32'd1);
        if (got_words.size() > 0) chk("post_rst_word", 32'(got_words[0]), 32'h0DA);
        sb_check("post_rst_sb");

        // Lone beat followed by a long idle period.
        cycle(1, 2'd2, 0, 0);
`ifdef WR_PACKER_TIMEOUT_EN
        for (int i = 0; i < TO; i++) cycle(0, 0, 0, 0);
        chk("timeout_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("timeout_din", 32'(fifo_din), 32'h02);
        chk("timeout_pf", 32'(partial_flush), 32'd1);
        cycle(0, 0, 0, 0);
`else
        for (int i = 0; i < 100; i++) cycle(0, 0, 0, 0);
        chk("no_timeout_push", 32'(got_words.size()), 32'd0);
        cycle(1, 2'd1, 1, 0);
        cycle(0, 0, 0, 0);
        chk("late_last_word", 32'(got_words.size() > 0 ? got_words[0] : -1), 32'h06);
`endif
        sb_check("idle_sb");

        // Randomized traffic against the reference model.
        base = m_wcnt;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        chk("rand_word_cnt", 32'(word_cnt), 32'((base + exp_words.size()) % 65536));
        sb_check("rand_sb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
